// File: rtl/mem_subsystem_cache_if.sv
// CPU-side request/response bundle for mem_subsystem_cache.
// The cache takes the slave modport; the core's MEM stage takes the master modport.
interface mem_subsystem_cache_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              LOAD;
    logic              STORE;
    logic [ADDR_W-1:0] input_address;
    logic [DATA_W-1:0] write_data;
    logic              ready;
    logic              done;
    logic [DATA_W-1:0] read_data;
    logic              hit;

    modport master (
        output LOAD, STORE, input_address, write_data,
        input  ready, done, read_data, hit
    );

    modport slave (
        input  LOAD, STORE, input_address, write_data,
        output ready, done, read_data, hit
    );
endinterface

// File: rtl/mem_subsystem_cache.sv
// Direct-mapped, write-back, write-allocate cache over a fixed-latency internal main memory.
// Optional statistics counters (hit/miss/writeback) are built when CACHE_STATS_EN is defined.
module mem_subsystem_cache #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int NUM_LINES   = 16,
    parameter int LINE_WORDS  = 4,
    parameter int MEM_WORDS   = 1024,
    parameter int MEM_LATENCY = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    mem_subsystem_cache_if.slave  bus
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count,
    output logic [31:0]           wb_count
`endif
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
    localparam int MA_W  = $clog2(MEM_WORDS);
    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(MEM_LATENCY - 1);
    localparam logic [OFF_W-1:0] WORD_LAST = OFF_W'(LINE_WORDS - 1);
    localparam logic [31:0]      MEM_KEY   = 32'hA5C3_5A3C;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOOKUP    = 3'd1;
    localparam logic [2:0] S_WRITEBACK = 3'd2;
    localparam logic [2:0] S_REFILL    = 3'd3;
    localparam logic [2:0] S_RESPOND   = 3'd4;

    logic [2:0]              state_r, state_nx_s;
    logic                    is_store_r;
    logic [ADDR_W-1:0]       addr_r;
    logic [DATA_W-1:0]       wdata_r;
    logic [OFF_W-1:0]        word_cnt_r;
    logic [LAT_W-1:0]        lat_cnt_r;
    logic                    ready_r, done_r, hit_r;
    logic [DATA_W-1:0]       rdata_r;

    logic [DATA_W-1:0]       mem_data_r [MEM_WORDS];
    logic [MEM_WORDS-1:0]    mem_written_r;
    logic [31:0]             mem_key_r;
    logic [DATA_W-1:0]       line_data_r [NUM_LINES*LINE_WORDS];
    logic [TAG_W-1:0]        tag_r [NUM_LINES];
    logic [NUM_LINES-1:0]    valid_r, dirty_r;

    logic [OFF_W-1:0]        req_off_s;
    logic [IDX_W-1:0]        req_idx_s;
    logic [TAG_W-1:0]        req_tag_s;
    logic                    hit_s, mem_step_s, last_word_s;
    logic [MA_W-1:0]         wb_addr_s, rf_addr_s;
    logic [DATA_W-1:0]       mem_rd_s, rsp_data_s;
    logic                    unused_s;

    assign req_off_s   = addr_r[2 +: OFF_W];
    assign req_idx_s   = addr_r[2+OFF_W +: IDX_W];
    assign req_tag_s   = addr_r[ADDR_W-1 -: TAG_W];
    assign unused_s    = ^addr_r[1:0];
    assign hit_s       = valid_r[req_idx_s] && (tag_r[req_idx_s] == req_tag_s);
    assign mem_step_s  = (lat_cnt_r == LAT_LAST);
    assign last_word_s = (word_cnt_r == WORD_LAST);
    // Word addresses above the memory range alias by simple truncation
    assign wb_addr_s   = MA_W'({tag_r[req_idx_s], req_idx_s, word_cnt_r});
    assign rf_addr_s   = MA_W'({req_tag_s, req_idx_s, word_cnt_r});
    assign mem_rd_s    = mem_written_r[rf_addr_s] ? mem_data_r[rf_addr_s] : DATA_W'(rf_addr_s);

    assign bus.ready     = ready_r;
    assign bus.done      = done_r;
    assign bus.read_data = rdata_r;
    assign bus.hit       = hit_r;

    // Next-state decode for the request FSM
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bus.LOAD || bus.STORE) state_nx_s = S_LOOKUP;
                else                       state_nx_s = S_IDLE;
            end
            S_LOOKUP: begin
                if (hit_s)                   state_nx_s = S_RESPOND;
                else if (dirty_r[req_idx_s]) state_nx_s = S_WRITEBACK;
                else                         state_nx_s = S_REFILL;
            end
            S_WRITEBACK: begin
                if (mem_step_s && last_word_s) state_nx_s = S_REFILL;
                else                           state_nx_s = S_WRITEBACK;
            end
            S_REFILL: begin
                if (mem_step_s && last_word_s) state_nx_s = S_RESPOND;
                else                           state_nx_s = S_REFILL;
            end
            S_RESPOND: state_nx_s = S_IDLE;
            default:   state_nx_s = S_IDLE;
        endcase
    end

    // Response word; the last refill word bypasses the line array since it lands on the same edge
    always_comb begin
        rsp_data_s = line_data_r[{req_idx_s, req_off_s}];
        if (is_store_r) begin
            rsp_data_s = wdata_r;
        end else if ((state_r == S_REFILL) && (req_off_s == word_cnt_r)) begin
            rsp_data_s = mem_rd_s;
        end else begin
            rsp_data_s = line_data_r[{req_idx_s, req_off_s}];
        end
    end

    // FSM state, request latch, memory-access counters and registered CPU outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= S_IDLE;
            is_store_r <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= '0;
            word_cnt_r <= '0;
            lat_cnt_r  <= '0;
            ready_r    <= 1'b1;
            done_r     <= 1'b0;
            hit_r      <= 1'b0;
            rdata_r    <= '0;
        end else begin
            state_r <= state_nx_s;
            ready_r <= (state_nx_s == S_IDLE);
            done_r  <= (state_nx_s == S_RESPOND);
            if (state_nx_s == S_RESPOND) begin
                rdata_r <= rsp_data_s;
                hit_r   <= (state_r == S_LOOKUP);
            end
            if ((state_r == S_IDLE) && (bus.LOAD || bus.STORE)) begin
                is_store_r <= bus.STORE;
                addr_r     <= bus.input_address;
                wdata_r    <= bus.write_data;
            end
            if ((state_r == S_WRITEBACK) || (state_r == S_REFILL)) begin
                if (mem_step_s) begin
                    lat_cnt_r  <= '0;
                    word_cnt_r <= word_cnt_r + 1'b1;
                end else begin
                    lat_cnt_r  <= lat_cnt_r + 1'b1;
                end
            end else begin
                lat_cnt_r  <= '0;
                word_cnt_r <= '0;
            end
        end
    end

    // Main-memory storage: written words only, no reset so it can map onto RAM
    always_ff @(posedge CLK) begin
        if (!RST && (state_r == S_WRITEBACK) && mem_step_s) begin
            mem_data_r[wb_addr_s] <= line_data_r[{req_idx_s, word_cnt_r}];
        end
    end

    // Written-word map; cleared only on the first reset after power-up (key not yet set),
    // so later resets leave memory contents intact
    always_ff @(posedge CLK) begin
        if (RST) begin
            if (mem_key_r == MEM_KEY) begin
                mem_key_r <= MEM_KEY;
            end else begin
                mem_key_r     <= MEM_KEY;
                mem_written_r <= '0;
            end
        end else if ((state_r == S_WRITEBACK) && mem_step_s) begin
            mem_written_r[wb_addr_s] <= 1'b1;
        end
    end

    // Cache data and tag arrays: refill words and store hits
    always_ff @(posedge CLK) begin
        if (!RST && (state_r == S_REFILL) && mem_step_s) begin
            line_data_r[{req_idx_s, word_cnt_r}] <= mem_rd_s;
            if (last_word_s) tag_r[req_idx_s] <= req_tag_s;
        end else if (!RST && (state_r == S_RESPOND) && is_store_r) begin
            line_data_r[{req_idx_s, req_off_s}] <= wdata_r;
        end
    end

    // Line valid/dirty state
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_r <= '0;
            dirty_r <= '0;
        end else if ((state_r == S_REFILL) && mem_step_s && last_word_s) begin
            valid_r[req_idx_s] <= 1'b1;
            dirty_r[req_idx_s] <= 1'b0;
        end else if ((state_r == S_RESPOND) && is_store_r) begin
            dirty_r[req_idx_s] <= 1'b1;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_r, miss_cnt_r, wb_cnt_r;
    assign hit_count  = hit_cnt_r;
    assign miss_count = miss_cnt_r;
    assign wb_count   = wb_cnt_r;

    // Lookup outcome and writeback-entry counters, free-running with wrap
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_cnt_r  <= 32'd0;
            miss_cnt_r <= 32'd0;
            wb_cnt_r   <= 32'd0;
        end else if (state_r == S_LOOKUP) begin
            if (hit_s) begin
                hit_cnt_r <= hit_cnt_r + 32'd1;
            end else begin
                miss_cnt_r <= miss_cnt_r + 32'd1;
                if (dirty_r[req_idx_s]) wb_cnt_r <= wb_cnt_r + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_mem_subsystem_cache.sv
// Self-checking bench for mem_subsystem_cache: vector table driven through a scoreboard,
// plus a hand-written reset-during-writeback sequence.
module tb_mem_subsystem_cache;
    typedef struct {
        logic        ld;
        logic        st;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        hit;
        logic [31:0] data;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        hit;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    vec_t vecs[$];
    exp_t sb[$];

    mem_subsystem_cache_if #(.DATA_W(32), .ADDR_W(32)) bus ();

`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count, wb_count;
    mem_subsystem_cache dut (.CLK(clk), .RST(rst), .bus(bus),
                             .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count));
`else
    mem_subsystem_cache dut (.CLK(clk), .RST(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: pop an expectation on every done pulse
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("read_data", bus.read_data, e.data);
                check("hit", {31'd0, bus.hit}, {31'd0, e.hit});
                check("latency", cyc - e.acc, e.lat);
            end
        end
    end

    task automatic add(input logic ld, input logic st, input logic [31:0] addr,
                       input logic [31:0] wdata, input int lat, input logic hit,
                       input logic [31:0] data);
        vec_t v;
        v.ld = ld; v.st = st; v.addr = addr; v.wdata = wdata;
        v.lat = lat; v.hit = hit; v.data = data;
        vecs.push_back(v);
    endtask

    // Issue one request at a negedge where ready is high; returns its accept cycle
    task automatic issue(input logic ld, input logic st, input logic [31:0] addr,
                         input logic [31:0] wdata, output int acc);
        int k;
        for (k = 0; k < 100; k++) begin
            if (bus.ready === 1'b1) break;
            @(negedge clk);
        end
        if (k == 100) check("ready_timeout", {31'd0, bus.ready}, 32'd1);
        acc = cyc;
        bus.LOAD = ld; bus.STORE = st; bus.input_address = addr; bus.write_data = wdata;
        @(posedge clk);
        #1;
        bus.LOAD = 1'b0; bus.STORE = 1'b0;
        bus.input_address = 32'hFFFF_FFFF; bus.write_data = 32'h5555_AAAA;
        @(negedge clk);
        check("ready_low_after_accept", {31'd0, bus.ready}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   acc;
        int   k;
        e.data = v.data; e.hit = v.hit; e.lat = v.lat;
        e.acc = cyc;
        sb.push_back(e);
        issue(v.ld, v.st, v.addr, v.wdata, acc);
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        if (k == 100) begin
            check("done_timeout", 32'd0, 32'd1);
            sb.delete();
        end
        @(negedge clk);
        check("ready_after_done", {31'd0, bus.ready}, 32'd1);
        check("done_one_cycle", {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int acc;
        bus.LOAD = 1'b0; bus.STORE = 1'b0;
        bus.input_address = 32'd0; bus.write_data = 32'd0;

        // phase 1
        add(1'b1, 1'b0, 32'h9c26_3203, 32'd0,          18, 1'b0, 32'h0000_0080);
        add(1'b1, 1'b0, 32'h9c26_3203, 32'd0,           2, 1'b1, 32'h0000_0080);
        add(1'b0, 1'b1, 32'h0000_0104, 32'hDEAD_BEEF,  18, 1'b0, 32'hDEAD_BEEF);
        add(1'b1, 1'b0, 32'h0000_0104, 32'd0,           2, 1'b1, 32'hDEAD_BEEF);
        add(1'b1, 1'b0, 32'h0000_0004, 32'd0,          34, 1'b0, 32'h0000_0001);
        add(1'b1, 1'b0, 32'h0000_0104, 32'd0,          18, 1'b0, 32'hDEAD_BEEF);
        add(1'b1, 1'b1, 32'h0000_0008, 32'h1234_5678,  18, 1'b0, 32'h1234_5678);
        add(1'b1, 1'b0, 32'h0000_0008, 32'd0,           2, 1'b1, 32'h1234_5678);
        add(1'b1, 1'b0, 32'h0000_0108, 32'd0,          34, 1'b0, 32'h0000_0042);
        add(1'b1, 1'b0, 32'h0000_0008, 32'd0,          18, 1'b0, 32'h1234_5678);
        add(1'b1, 1'b0, 32'h0000_003C, 32'd0,          18, 1'b0, 32'h0000_000F);
        add(1'b0, 1'b1, 32'h0000_0008, 32'hCAFE_F00D,   2, 1'b1, 32'hCAFE_F00D);
        // phase 2, after the aborted writeback
        add(1'b1, 1'b0, 32'h0000_0208, 32'd0,          18, 1'b0, 32'h0000_0082);
        add(1'b1, 1'b0, 32'h0000_0008, 32'd0,          18, 1'b0, 32'h1234_5678);
        add(1'b1, 1'b0, 32'h0000_003C, 32'd0,          18, 1'b0, 32'h0000_000F);
        add(1'b1, 1'b0, 32'h0000_100C, 32'd0,          18, 1'b0, 32'h0000_0003);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", {31'd0, bus.ready}, 32'd1);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_hit", {31'd0, bus.hit}, 32'd0);
        check("reset_read_data", bus.read_data, 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i]);
`ifdef CACHE_STATS_EN
            if (i == 1) begin
                check("stat_hit", hit_count, 32'd1);
                check("stat_miss", miss_count, 32'd1);
                check("stat_wb", wb_count, 32'd0);
            end
`endif
        end

        // Reset five cycles into the writeback of a dirty miss: no done, ready next cycle
        issue(1'b1, 1'b0, 32'h0000_0208, 32'd0, acc);
        while (cyc < acc + 7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", {31'd0, bus.ready}, 32'd1);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        repeat (40) @(negedge clk);

        for (int i = 12; i < vecs.size(); i++) run_vec(vecs[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
